hazard_controller: RTL and testbench

Central pipeline sequencer for the 5-stage RV32 core with SPI peripheral.
- Generates operand-forwarding selects, load-use stalls and branch/jump flushes.
- Freezes the whole pipeline while a memory-mapped peripheral access in M waits for ready.
- Sits beside the fetch, decode, execute, memory and writeback stages. Drives FlushE of the decode-to-execute pipeline register and the stall/flush inputs of the other stages.

---
 rtl/hazard_controller.sv | 163 ++++++++++++++++
 tb/tb_hazard_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: forwarding selects, load-use stalls, branch flushes and peripheral wait freeze.
// Optional macro HAZARD_PERF_CNT_EN adds StallCycles/FlushCount performance counters.
module hazard_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] RS1_D,
    input  logic [4:0] RS2_D,
    input  logic [4:0] RS1_E,
    input  logic [4:0] RS2_E,
    input  logic [4:0] RD_E,
    input  logic [4:0] RD_M,
    input  logic [4:0] RD_W,
    input  logic [1:0] ResultSrcE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       PCSrcE,
    input  logic       PeriphReqM,
    input  logic       PeriphReadyM,
    input  logic       ErrClr,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       AbortM,
    output logic       TimeoutErr
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCount
`endif
);

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_ABORT} state_t;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_timeout_err;

    logic       w_ld_stall;
    logic       w_pstall;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic rwm,
                                           input logic [4:0] rdm, input logic rww,
                                           input logic [4:0] rdw);
        if (rwm && (rdm != 5'd0) && (rdm == rs))
            return 2'b10;
        else if (rww && (rdw != 5'd0) && (rdw == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        w_fwd_a    = fwd_sel(RS1_E, RegWriteM, RD_M, RegWriteW, RD_W);
        w_fwd_b    = fwd_sel(RS2_E, RegWriteM, RD_M, RegWriteW, RD_W);
        w_ld_stall = (ResultSrcE == 2'b01) && (RD_E != 5'd0) &&
                     ((RD_E == RS1_D) || (RD_E == RS2_D));
        // Freeze releases combinationally on ready, and on the final wait cycle before abort.
        w_pstall   = ((r_state == S_RUN)  && PeriphReqM && !PeriphReadyM) ||
                     ((r_state == S_WAIT) && !PeriphReadyM && (r_count != LP_LAST));
    end

    always_comb begin
        ForwardAE  = 2'b00;
        ForwardBE  = 2'b00;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        AbortM     = 1'b0;
        TimeoutErr = r_timeout_err;
        if (rst) begin
            ForwardAE = w_fwd_a;
            ForwardBE = w_fwd_b;
            AbortM    = (r_state == S_ABORT);
            if (w_pstall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
            end else begin
                StallF = w_ld_stall;
                StallD = w_ld_stall;
                FlushD = PCSrcE;
                FlushE = w_ld_stall || PCSrcE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_RUN;
            r_count       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (ErrClr)
                        r_timeout_err <= 1'b0;
                    if (PeriphReqM && !PeriphReadyM) begin
                        r_state <= S_WAIT;
                        r_count <= CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (ErrClr)
                        r_timeout_err <= 1'b0;
                    if (PeriphReadyM) begin
                        r_state <= S_RUN;
                        r_count <= '0;
                    end else if (r_count == LP_LAST) begin
                        r_state <= S_ABORT;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                S_ABORT: begin
                    r_timeout_err <= 1'b1;
                    r_state       <= S_RUN;
                    r_count       <= '0;
                end
                default: begin
                    r_state <= S_RUN;
                    r_count <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (StallF)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (FlushD)
                r_flush_count <= r_flush_count + 32'd1;
        end
    end

    assign StallCycles = r_stall_cycles;
    assign FlushCount  = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed vector bench for hazard_controller: forwarding/stall/flush table plus freeze, timeout and reset sequences.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
    logic [1:0] ResultSrcE;
    logic       RegWriteM, RegWriteW, PCSrcE, PeriphReqM, PeriphReadyM, ErrClr;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, AbortM, TimeoutErr;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] StallCycles, FlushCount;
`endif

    always #5 clk = ~clk;

    hazard_controller #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E),
        .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
        .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .PeriphReqM(PeriphReqM), .PeriphReadyM(PeriphReadyM), .ErrClr(ErrClr),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .AbortM(AbortM), .TimeoutErr(TimeoutErr)
`ifdef HAZARD_PERF_CNT_EN
        , .StallCycles(StallCycles), .FlushCount(FlushCount)
`endif
    );

    // {FwdA, FwdB, StallF, StallD, StallE, StallM, FlushD, FlushE, AbortM, TimeoutErr}
    logic [11:0] act;
    assign act = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, AbortM, TimeoutErr};

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0] rsrc;
        logic       rwm, rww, pcsrc;
        logic [1:0] efa, efb;
        logic       est, efd, efe;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    function automatic logic [11:0] pk(input logic [1:0] fa, input logic [1:0] fb,
                                       input logic sf, input logic sd, input logic se,
                                       input logic sm, input logic fd, input logic fe,
                                       input logic ab, input logic te);
        return {fa, fb, sf, sd, se, sm, fd, fe, ab, te};
    endfunction

    task automatic chk(input string nm, input logic [11:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%b required=%b", nm, act, exp);
    endtask

    task automatic chk_int(input string nm, input int a, input int e);
        n_checks++;
        if (a == e) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d", nm, a, e);
    endtask

    task automatic idle();
        RS1_D = '0; RS2_D = '0; RS1_E = '0; RS2_E = '0;
        RD_E = '0; RD_M = '0; RD_W = '0; ResultSrcE = '0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
        PeriphReqM = 1'b0; PeriphReadyM = 1'b0; ErrClr = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    localparam logic [11:0] FREEZE = 12'b0000_1111_0000;

    initial begin
        int stalls;
        bit seen;

        vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd6, 5'd0, 5'd5, 5'd6, 2'b00, 1'b1, 1'b1, 1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd5, 5'd0, 5'd5, 5'd5, 2'b00, 1'b1, 1'b1, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{5'd0, 5'd0, 5'd3, 5'd3, 5'd0, 5'd3, 5'd3, 2'b00, 1'b0, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{5'd0, 5'd0, 5'd4, 5'd3, 5'd0, 5'd3, 5'd3, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{5'd1, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{5'd7, 5'd2, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{5'd0, 5'd9, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{5'd8, 5'd6, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};

        // Reset with hazard-producing inputs: everything must read zero.
        idle();
        rst = 1'b0;
        RegWriteM = 1'b1; RD_M = 5'd5; RS1_E = 5'd5; PCSrcE = 1'b1;
        ResultSrcE = 2'b01; RD_E = 5'd3; RS1_D = 5'd3;
        #2 chk("reset", 12'd0);
        #10 rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            next_cycle();
            idle();
            RS1_D = vecs[i].rs1d; RS2_D = vecs[i].rs2d;
            RS1_E = vecs[i].rs1e; RS2_E = vecs[i].rs2e;
            RD_E = vecs[i].rde; RD_M = vecs[i].rdm; RD_W = vecs[i].rdw;
            ResultSrcE = vecs[i].rsrc; RegWriteM = vecs[i].rwm;
            RegWriteW = vecs[i].rww; PCSrcE = vecs[i].pcsrc;
            @(negedge clk);
            chk($sformatf("vec%0d", i), pk(vecs[i].efa, vecs[i].efb, vecs[i].est, vecs[i].est,
                                           1'b0, 1'b0, vecs[i].efd, vecs[i].efe, 1'b0, 1'b0));
        end

        // Peripheral wait of 3 cycles with a load-use hazard underneath the freeze.
        next_cycle();
        idle();
        PeriphReqM = 1'b1;
        ResultSrcE = 2'b01; RD_E = 5'd7; RS1_D = 5'd7;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next_cycle();
            @(negedge clk);
            chk($sformatf("wait3_c%0d", i), FREEZE);
        end
        next_cycle();
        PeriphReadyM = 1'b1;
        @(negedge clk);
        chk("wait3_release", pk(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        next_cycle();
        idle();
        @(negedge clk);
        chk("wait3_after", 12'd0);

        // Timeout with a pending redirect held in the frozen E stage.
        next_cycle();
        idle();
        PeriphReqM = 1'b1; PCSrcE = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i > 0) next_cycle();
            @(negedge clk);
            chk($sformatf("tmo_c%0d", i), FREEZE);
        end
        next_cycle();
        @(negedge clk);
        chk("tmo_last_wait", pk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        next_cycle();
        ErrClr = 1'b1;
        @(negedge clk);
        chk("tmo_abort", pk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
        next_cycle();
        idle();
        @(negedge clk);
        chk("tmo_err_set", pk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));

        // Reset asserted mid-WAIT at count 4.
        next_cycle();
        PeriphReqM = 1'b1; PCSrcE = 1'b1;
        RegWriteM = 1'b1; RD_M = 5'd5; RS1_E = 5'd5;
        @(negedge clk);
        chk("rstw_enter", pk(2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < 4; i++) next_cycle();
        #1 rst = 1'b0;
        #1 chk("rstw_asserted", 12'd0);
        @(negedge clk);
        idle();
        rst = 1'b1;
        #1 chk("rstw_released", 12'd0);

        // Counter restarts from zero: a full timeout freezes for exactly 15 cycles.
        next_cycle();
        PeriphReqM = 1'b1;
        stalls = 0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (AbortM) begin
                seen = 1'b1;
                break;
            end
            if (StallF) stalls++;
            next_cycle();
        end
        chk_int("tmo2_abort_seen", int'(seen), 1);
        chk_int("tmo2_stall_cycles", stalls, 15);
        next_cycle();
        idle();
        ErrClr = 1'b1;
        @(negedge clk);
        chk("tmo2_err_before_clr", pk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        next_cycle();
        ErrClr = 1'b0;
        @(negedge clk);
        chk("tmo2_err_cleared", 12'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
